pid_multi: RTL
==============

# pid_multi

Time-multiplexed, N_CH-channel PID controller; the parametrised successor to the single-channel `pid` block. One shared multiplier serves all channels in turn. Each channel has its own gain and limit registers, plus an anti-windup integrator clamp and output saturation. It sits between the measurement front-end and the actuator drive, and its gains are loaded through the same write-port protocol as `pid`.

## Interface
- D_WIDTH, 18, signed data, gain and output width.
- N_CH, 4, channel count (1..16).
- FRAC_BITS, 12, gain fraction bits (gain 1<<FRAC_BITS = 1.0).
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; clears all state and config.
- write_enable  in  1  active-low config write strobe.
- iterate_enable  in  1  level; high = run sweeps continuously.
- reg_addr  in  D_WIDTH  [1:0] = register index, [2+:$clog2(N_CH)] = channel.
- reg_data  in  D_WIDTH  signed write data.
- target  in  N_CH*D_WIDTH  signed setpoints, channel c at [c*D_WIDTH+:D_WIDTH].
- measurement  in  N_CH*D_WIDTH  signed measurements, same packing.
- out_clocked  out  N_CH*D_WIDTH  registered signed controller outputs.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.

## Operation
- Register index per channel: 0 kp, 1 ki, 2 kd, 3 ilim. Write on a clock edge with write_enable=0. Channel field ≥ N_CH: write ignored. Writes are accepted at any time, including while busy.
- ilim < 0 is treated as 0, which holds the integrator at 0.
- FSM states:
  - IDLE → ERR when iterate_enable=1.
  - ERR → P → I → D → OUT, one cycle each.
  - OUT → ERR (next channel) or IDLE (after channel N_CH-1).
- ERR, channel c:
  - snapshot kp, ki, kd, ilim of c;
  - e = target[c] − measurement[c], D_WIDTH+1 bits;
  - integ_n = clamp(integ[c] + e, −ilim, +ilim);
  - deriv = e − e_prev[c], D_WIDTH+2 bits.
- P, I, D: one product per cycle into accumulator acc (2*D_WIDTH+4 bits):
  - P: acc = kp*e;
  - I: acc += ki*integ_n;
  - D: acc += kd*deriv.
- OUT:
  - u = acc >>> FRAC_BITS (arithmetic), saturated to [−2^(D_WIDTH−1), 2^(D_WIDTH−1)−1];
  - write out_clocked[c] = u, integ[c] = integ_n, e_prev[c] = e.
- iterate_enable low mid-sweep: the current sweep completes, then the FSM stays in IDLE.
- Reset (reset=0) mid-sweep: the sweep aborts. All outputs, gains, ilim, integ and e_prev go to 0 and the FSM goes to IDLE.

## Timing
- Reset values: out_clocked=0, busy=0, done=0, all registers 0.
- iterate_enable is sampled only in IDLE. ERR for ch0 is in the cycle after the sampling edge.
- Per-channel latency is 5 cycles. out_clocked[c] updates at the edge ending OUT of c. Other channels' outputs hold.
- busy is high from ERR(ch0) through OUT(ch N_CH−1).
- done is high for exactly one cycle: the first IDLE cycle after the last OUT. out_clocked already holds all new values in that cycle.
- Continuous operation: sweep period is 5*N_CH+1 cycles.
- target/measurement of channel c are sampled only in ERR of c. They may change at other times.
- A write landing on the ERR edge of the same channel is not visible until the next sweep. The snapshot takes the pre-edge value.
- No combinational input-to-output paths.

## Structure
- Package pid_pkg holds:
  - the FSM state enum (IDLE, ERR, P, I, D, OUT);
  - the register index constants (REG_KP=0, REG_KI=1, REG_KD=2, REG_ILIM=3);
  - a sat function.
- Sub-module pid_sat: a combinational arithmetic shift plus saturation from the accumulator width to D_WIDTH. It is parametrised by input width, D_WIDTH and FRAC_BITS, and is instantiated once.
- Register file and channel state are arrays indexed by channel counter. There is one multiplier whose operands are muxed by state.

## Test plan
All scenarios use N_CH=2, D_WIDTH=18, FRAC_BITS=12, and apply reset first.
- Proportional: ch0 kp=4096, target=32768, measurement=65536, one sweep. Required: out ch0=−32768, out ch1=0, done pulses 11 cycles after the iterate_enable sample edge.
- Saturation: ch0 kp=131071, error −32768. Required: out ch0=−131072. Error +32768 gives 131071.
- Integrator clamp: ch1 ki=4096, ilim=50000, error=32768 held over three sweeps. Required: out ch1 = 32768, then 50000, then 50000.
- Derivative: ch0 kd=4096, error 0 in sweep 1, then 1000 in sweep 2, then 1000 in sweep 3. Required: outputs 0, 1000, 0.
- Address decode: write kp to channel field 2, which is out of range. Required: no register changes and all outputs stay 0. A write to ch1 does not affect ch0.
- Control:
  - iterate_enable drops mid-sweep: the sweep finishes, done pulses once, and busy stays 0 afterwards.
  - reset=0 at the P state of ch1: the next cycle has busy=0 and all out_clocked=0, and a re-run with kp=0 gives 0.

Source files
------------

// File: rtl/pid_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pid_pkg : shared types, register indices and saturation helper   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_P    = 3'd2,
    S_I    = 3'd3,
    S_D    = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  localparam logic [1:0] REG_KP   = 2'd0;
  localparam logic [1:0] REG_KI   = 2'd1;
  localparam logic [1:0] REG_KD   = 2'd2;
  localparam logic [1:0] REG_ILIM = 2'd3;

  localparam logic [1:0] SAT_NONE = 2'b00;
  localparam logic [1:0] SAT_HI   = 2'b01;
  localparam logic [1:0] SAT_LO   = 2'b10;

  // Classifies v against the signed range of a w-bit word.
  function automatic logic [1:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pid_sat.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pid_sat : arithmetic right shift and saturation to D_WIDTH        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pid_sat
  import pid_pkg::*;
#(
  parameter int IN_W      = 40,
  parameter int D_WIDTH   = 18,
  parameter int FRAC_BITS = 12
) (
  input  logic signed [IN_W-1:0]    acc_i,
  output logic signed [D_WIDTH-1:0] sat_o
);

  localparam logic signed [D_WIDTH-1:0] MAX_V = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH-1:0] MIN_V = {1'b1, {(D_WIDTH-1){1'b0}}};

  logic signed [IN_W-1:0] w_sh;
  logic [1:0]             w_dir;

  assign w_sh  = acc_i >>> FRAC_BITS;
  assign w_dir = sat(64'(w_sh), D_WIDTH);

  always_comb begin
    case (w_dir)
      SAT_HI:  sat_o = MAX_V;
      SAT_LO:  sat_o = MIN_V;
      default: sat_o = w_sh[D_WIDTH-1:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pid_multi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pid_multi : time-multiplexed N_CH-channel PID, one shared multiply|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pid_multi
  import pid_pkg::*;
#(
  parameter int D_WIDTH   = 18,
  parameter int N_CH      = 4,
  parameter int FRAC_BITS = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      write_enable,
  input  logic                      iterate_enable,
  input  logic [D_WIDTH-1:0]        reg_addr,
  input  logic signed [D_WIDTH-1:0] reg_data,
  input  logic [N_CH*D_WIDTH-1:0]   target,
  input  logic [N_CH*D_WIDTH-1:0]   measurement,
  output logic [N_CH*D_WIDTH-1:0]   out_clocked,
  output logic                      busy,
  output logic                      done
);

  localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACC_W  = 2*D_WIDTH + 4;
  localparam int PROD_W = 2*D_WIDTH + 2;
  localparam logic [CHW-1:0]       LAST_CH  = CHW'(N_CH - 1);
  localparam logic [D_WIDTH-3:0]   NCH_ADDR = (D_WIDTH-2)'(N_CH);

  state_t                    state_q;
  logic [CHW-1:0]            ch_q;
  logic                      busy_q;
  logic                      done_q;

  logic signed [D_WIDTH-1:0] kp_q    [N_CH];
  logic signed [D_WIDTH-1:0] ki_q    [N_CH];
  logic signed [D_WIDTH-1:0] kd_q    [N_CH];
  logic signed [D_WIDTH-1:0] ilim_q  [N_CH];
  logic signed [D_WIDTH-1:0] integ_q [N_CH];
  logic signed [D_WIDTH:0]   eprev_q [N_CH];
  logic signed [D_WIDTH-1:0] out_q   [N_CH];

  logic signed [D_WIDTH-1:0] kps_q;
  logic signed [D_WIDTH-1:0] kis_q;
  logic signed [D_WIDTH-1:0] kds_q;
  logic signed [D_WIDTH:0]   e_q;
  logic signed [D_WIDTH-1:0] integn_q;
  logic signed [D_WIDTH+1:0] deriv_q;
  logic signed [ACC_W-1:0]   acc_q;

  logic signed [D_WIDTH:0]   e_d;
  logic signed [D_WIDTH-1:0] integn_d;
  logic signed [D_WIDTH+1:0] deriv_d;
  logic signed [ACC_W-1:0]   acc_d;

  logic signed [D_WIDTH-1:0] w_tgt  [N_CH];
  logic signed [D_WIDTH-1:0] w_meas [N_CH];
  logic signed [D_WIDTH-1:0] w_t;
  logic signed [D_WIDTH-1:0] w_m;
  logic signed [D_WIDTH-1:0] w_ilim;
  logic signed [D_WIDTH-1:0] w_integ;
  logic signed [D_WIDTH:0]   w_eprev;
  logic signed [D_WIDTH+1:0] w_isum;
  logic signed [D_WIDTH+1:0] w_ilim_ext;
  logic signed [D_WIDTH-1:0] w_mul_a;
  logic signed [D_WIDTH+1:0] w_mul_b;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [D_WIDTH-1:0] w_u;
  logic                      w_wr_ok;
  logic [CHW-1:0]            w_wr_ch;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_tgt[g]  = target[g*D_WIDTH +: D_WIDTH];
    assign w_meas[g] = measurement[g*D_WIDTH +: D_WIDTH];
    assign out_clocked[g*D_WIDTH +: D_WIDTH] = out_q[g];
  end

  assign busy = busy_q;
  assign done = done_q;

  // The whole upper address field is decoded so aliases of valid channels are rejected.
  assign w_wr_ok = (reg_addr[D_WIDTH-1:2] < NCH_ADDR);
  assign w_wr_ch = reg_addr[2 +: CHW];

  always_comb begin
    w_t        = w_tgt[ch_q];
    w_m        = w_meas[ch_q];
    w_integ    = integ_q[ch_q];
    w_eprev    = eprev_q[ch_q];
    w_ilim     = ilim_q[ch_q][D_WIDTH-1] ? '0 : ilim_q[ch_q];
    e_d        = {w_t[D_WIDTH-1], w_t} - {w_m[D_WIDTH-1], w_m};
    w_isum     = {{2{w_integ[D_WIDTH-1]}}, w_integ} + {e_d[D_WIDTH], e_d};
    w_ilim_ext = {2'b00, w_ilim};
    if (w_isum > w_ilim_ext)       integn_d = w_ilim;
    else if (w_isum < -w_ilim_ext) integn_d = -w_ilim;
    else                           integn_d = w_isum[D_WIDTH-1:0];
    deriv_d    = {e_d[D_WIDTH], e_d} - {w_eprev[D_WIDTH], w_eprev};
  end

  always_comb begin
    case (state_q)
      S_P: begin
        w_mul_a = kps_q;
        w_mul_b = {e_q[D_WIDTH], e_q};
      end
      S_I: begin
        w_mul_a = kis_q;
        w_mul_b = {{2{integn_q[D_WIDTH-1]}}, integn_q};
      end
      default: begin
        w_mul_a = kds_q;
        w_mul_b = deriv_q;
      end
    endcase
    w_prod = {{(D_WIDTH+2){w_mul_a[D_WIDTH-1]}}, w_mul_a}
           * {{D_WIDTH{w_mul_b[D_WIDTH+1]}}, w_mul_b};
    acc_d  = (state_q == S_P) ? {{2{w_prod[PROD_W-1]}}, w_prod}
                              : acc_q + {{2{w_prod[PROD_W-1]}}, w_prod};
  end

  pid_sat #(
    .IN_W      (ACC_W),
    .D_WIDTH   (D_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .acc_i (acc_q),
    .sat_o (w_u)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      kps_q    <= '0;
      kis_q    <= '0;
      kds_q    <= '0;
      e_q      <= '0;
      integn_q <= '0;
      deriv_q  <= '0;
      acc_q    <= '0;
      for (int k = 0; k < N_CH; k++) begin
        kp_q[k]    <= '0;
        ki_q[k]    <= '0;
        kd_q[k]    <= '0;
        ilim_q[k]  <= '0;
        integ_q[k] <= '0;
        eprev_q[k] <= '0;
        out_q[k]   <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iterate_enable) begin
            state_q <= S_ERR;
            ch_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_ERR: begin
          kps_q    <= kp_q[ch_q];
          kis_q    <= ki_q[ch_q];
          kds_q    <= kd_q[ch_q];
          e_q      <= e_d;
          integn_q <= integn_d;
          deriv_q  <= deriv_d;
          state_q  <= S_P;
        end
        S_P: begin
          acc_q   <= acc_d;
          state_q <= S_I;
        end
        S_I: begin
          acc_q   <= acc_d;
          state_q <= S_D;
        end
        S_D: begin
          acc_q   <= acc_d;
          state_q <= S_OUT;
        end
        S_OUT: begin
          out_q[ch_q]   <= w_u;
          integ_q[ch_q] <= integn_q;
          eprev_q[ch_q] <= e_q;
          if (ch_q == LAST_CH) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ch_q    <= ch_q + CHW'(1);
            state_q <= S_ERR;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (!write_enable && w_wr_ok) begin
        case (reg_addr[1:0])
          REG_KP:  kp_q[w_wr_ch]   <= reg_data;
          REG_KI:  ki_q[w_wr_ch]   <= reg_data;
          REG_KD:  kd_q[w_wr_ch]   <= reg_data;
          default: ilim_q[w_wr_ch] <= reg_data;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
